// File: rtl/alu_driver_pkg.sv
// Shared types and constants for the ALU command/response driver.
// Opcode set, flag layout and the reference bitwise evaluation live here.
package alu_driver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_MAX  = OP_NAND;

  // Bit positions inside rsp_flags.
  localparam int FLAG_COUT = 3;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

  function automatic logic op_legal(input logic [3:0] sel);
    return (sel <= OP_MAX);
  endfunction

  function automatic logic [31:0] op_eval(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  sel);
    logic [31:0] y;
    case (sel)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = 32'd0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/alu_driver_golden.sv
// Golden bitwise model of the held ALU operands with a sticky mismatch flag.
// Built only when ALU_DRIVER_CHECK_EN is defined.
module alu_driver_golden
  import alu_driver_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cap_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] y_i,
  output logic        mismatch_o
);

  logic [31:0] exp_s;
  logic        mismatch_q;

  assign exp_s = op_eval(a_i, b_i, sel_i);

  // Sticky: once the ALU disagrees on a capture edge, only rst clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mismatch_q <= 1'b0;
    end else if (cap_i && (exp_s != y_i)) begin
      mismatch_q <= 1'b1;
    end else begin
      mismatch_q <= mismatch_q;
    end
  end

  assign mismatch_o = mismatch_q;

endmodule

// File: rtl/alu_driver.sv
// Drives an external combinational ALU from a valid/ready command stream and
// returns its result on a valid/ready response port. Optional checker: ALU_DRIVER_CHECK_EN.
module alu_driver
  import alu_driver_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_sel,
  input  logic        cmd_cin,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [3:0]  alu_sel,
  output logic        alu_Cin,
  input  logic [31:0] alu_Y,
  input  logic        alu_Cout,
  input  logic        alu_Negative,
  input  logic        alu_Zero,
  input  logic        alu_Overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [15:0] op_count,
  output logic        mismatch
);

  // Counter starts at SETTLE_CYCLES-1 so capture lands SETTLE_CYCLES edges after accept.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_sel_q;
  logic        alu_cin_q;
  logic [31:0] rsp_y_q;
  logic [3:0]  rsp_flags_q;
  logic        rsp_err_q;
  logic [15:0] op_count_q;
  logic [3:0]  cnt_q;

  // Command accept, settle countdown, response capture and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_sel_q   <= 4'd0;
      alu_cin_q   <= 1'b0;
      rsp_y_q     <= 32'd0;
      rsp_flags_q <= 4'd0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= 16'd0;
      cnt_q       <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (op_legal(cmd_sel)) begin
              alu_a_q   <= cmd_a;
              alu_b_q   <= cmd_b;
              alu_sel_q <= cmd_sel;
              alu_cin_q <= cmd_cin;
              cnt_q     <= CNT_INIT;
              state_q   <= SETTLE;
            end else begin
              // Illegal opcode leaves the ALU inputs alone and answers at once.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_y_q     <= 32'd0;
              rsp_flags_q <= 4'd0;
              state_q     <= RESP;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == 4'd0) begin
            rsp_y_q                <= alu_Y;
            rsp_flags_q[FLAG_COUT] <= alu_Cout;
            rsp_flags_q[FLAG_NEG]  <= alu_Negative;
            rsp_flags_q[FLAG_ZERO] <= alu_Zero;
            rsp_flags_q[FLAG_OVF]  <= alu_Overflow;
            rsp_err_q              <= 1'b0;
            rsp_valid_q            <= 1'b1;
            state_q                <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 16'd1;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign alu_A     = alu_a_q;
  assign alu_B     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign alu_Cin   = alu_cin_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

`ifdef ALU_DRIVER_CHECK_EN
  logic cap_s;

  assign cap_s = (state_q == SETTLE) && (cnt_q == 4'd0);

  alu_driver_golden u_golden (
    .clk_i      (clk),
    .rst_i      (rst),
    .cap_i      (cap_s),
    .a_i        (alu_a_q),
    .b_i        (alu_b_q),
    .sel_i      (alu_sel_q),
    .y_i        (alu_Y),
    .mismatch_o (mismatch)
  );
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving the cycles from operand drive to result sample (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  driver accepts a command.
REQ-006 SHALL have ports cmd_a, cmd_b  input  32 each  operands.
REQ-007 SHALL have ports cmd_sel  input  4  opcode, and cmd_cin  input  1  carry-in.
REQ-008 SHALL have ports alu_A, alu_B  output  32 each, alu_sel  output  4, alu_Cin  output  1; all registered and driving the ALU.
REQ-009 SHALL have ports alu_Y  input  32, and alu_Cout, alu_Negative, alu_Zero, alu_Overflow  input  1 each; all are ALU results.
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-012 SHALL have ports rsp_y  output  32, rsp_flags  output  4 {Cout,Negative,Zero,Overflow}, and rsp_err  output  1  illegal opcode.
REQ-013 SHALL have port op_count  output  16  count of completed responses.
REQ-014 SHALL have port mismatch  output  1  sticky checker mismatch.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE and RESP.
- IDLE to SETTLE: on accept of a legal opcode.
- IDLE to RESP: on accept of an illegal opcode.
- SETTLE to RESP: when the settle counter expires.
- RESP to IDLE: on rsp handshake.
REQ-016 SHALL assert cmd_ready only in IDLE; a command is accepted on an edge with cmd_valid and cmd_ready both high.
REQ-017 SHALL, on the accept edge, load alu_A/alu_B/alu_sel/alu_Cin from cmd_* and hold them until the next accept or reset.
REQ-018 SHALL define legal opcodes as 4'b0000-4'b0101 (AND, OR, NOT, NOR, XOR, NAND).
REQ-019 SHALL, on the edge ending the settle period, capture alu_Y and the four flags into rsp_y/rsp_flags and set rsp_valid.
- That edge is the accept edge + SETTLE_CYCLES.
- With the default, rsp_valid is high in the second cycle after accept.
REQ-020 SHALL treat an illegal opcode as follows:
- alu_* outputs are not updated.
- RESP is entered on the accept edge.
- rsp_err=1, rsp_y=0, rsp_flags=0.
REQ-021 SHALL hold rsp_y, rsp_flags and rsp_err stable while rsp_valid is high and rsp_ready is low.
REQ-022 SHALL, on a rsp handshake edge, clear rsp_valid, enter IDLE and increment op_count; cmd_ready rises the following cycle, so there is no same-cycle command accept.
REQ-023 SHALL let op_count wrap from 16'hFFFF to 16'h0000.
REQ-024 SHALL ignore cmd_valid outside IDLE and ignore rsp_ready outside RESP.

Reset
REQ-025 SHALL, with rst high at an edge, set the following regardless of state, and SHALL discard any in-flight command:
- state = IDLE
- cmd_ready = 1 in the next cycle
- rsp_valid = 0
- alu_A, alu_B, alu_sel, alu_Cin, rsp_y, rsp_flags, rsp_err = 0
- op_count = 0
- mismatch = 0
REQ-026 SHALL give rst priority over a simultaneous handshake.

Configuration
REQ-027 SHALL honour macro ALU_DRIVER_CHECK_EN.
- Defined: a golden model computes the expected 32-bit bitwise result of the legal opcode from the held operands. On the capture edge, mismatch is set and held if the expected result differs from alu_Y; only rst clears it.
- Undefined: mismatch is tied to 0 and no checker logic exists.

Structure
REQ-028 SHALL place in shared package alu_driver_pkg: the FSM state encoding, the opcode constants OP_AND..OP_NAND, the flag bit indices and the legal-opcode maximum.
REQ-029 SHALL implement the checker as a sub-module alu_driver_golden, instantiated only under ALU_DRIVER_CHECK_EN.

Verification
REQ-030 SHALL cover: reset, then cmd a=32'h1, b=32'h1, sel=0 -> alu_A=1 after the accept edge; rsp_valid two cycles later with rsp_y[0]=1 from the ALU; op_count=1 after the handshake.
REQ-031 SHALL cover: cmd sel=4'b1001 -> rsp_valid in the cycle after accept with rsp_err=1, rsp_y=0; alu_sel unchanged.
REQ-032 SHALL cover: rsp_ready held low for 5 cycles -> rsp fields stable, cmd_ready low, a second cmd_valid not accepted.
REQ-033 SHALL cover: rst asserted in SETTLE -> next cycle rsp_valid=0, cmd_ready=1, all outputs 0, and no response is ever produced for the aborted command.
REQ-034 SHALL cover: preload op_count to 16'hFFFF via 65535 transactions, then complete one more -> op_count=0.
REQ-035 SHALL cover, with ALU_DRIVER_CHECK_EN defined: sel=4'b0100, a=1, b=1 with the ALU stubbed to return Y=1 -> mismatch=1, held until rst.
